// File: rtl/wc_pkg.sv
// Shared constants and types for the Winograd F(3,5) tile scheduler.
package wc_pkg;
  localparam int DW     = 10;
  localparam int M      = 3;
  localparam int R      = 5;
  localparam int T      = M + R - 1;
  localparam int WC_LAT = 2;

  typedef logic [DW-1:0] wc_sample_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAIT,
    S_DRAIN,
    S_FIN
  } wc_sched_state_t;
endpackage

// File: rtl/wc_window.sv
// T-deep sample shift register; slot 0 holds the oldest sample.
module wc_window #(
  parameter int DW = 10,
  parameter int T  = 7
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          shift_i,
  input  logic [DW-1:0] data_i,
  output logic [T*DW-1:0] taps_o
);
  logic [T*DW-1:0] win_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q <= '0;
    end else if (shift_i) begin
      win_q <= {data_i, win_q[T*DW-1:DW]};
    end
  end

  assign taps_o = win_q;
endmodule

// File: rtl/wc_tile_sched.sv
// Builds overlapping stride-M windows for WC, captures Z after the core
// latency and streams the M results out serially, one tile in flight.
module wc_tile_sched #(
  parameter int DW     = wc_pkg::DW,
  parameter int M      = wc_pkg::M,
  parameter int R      = wc_pkg::R,
  parameter int T      = M + R - 1,
  parameter int WC_LAT = wc_pkg::WC_LAT,
  parameter int NW     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NW-1:0]   n_tiles,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic [T*DW-1:0] wc_D,
  input  logic [M*DW-1:0] wc_Z,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic            busy,
  output logic            done
);
  import wc_pkg::*;

  localparam int WCW = (WC_LAT > 0) ? $clog2(WC_LAT + 1) : 1;

  wc_sched_state_t state_q, state_d;
  logic [2:0]      need_q, need_d;
  logic [1:0]      oidx_q, oidx_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [NW-1:0]   tiles_q, tiles_d;
  logic [M*DW-1:0] res_q, res_d;
  logic            shift;

  assign shift = (state_q == S_FILL) && in_valid;

  wc_window #(
    .DW (DW),
    .T  (T)
  ) u_window (
    .clk_i   (clk),
    .rst_ni  (rst),
    .shift_i (shift),
    .data_i  (in_data),
    .taps_o  (wc_D)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      need_q  <= '0;
      oidx_q  <= '0;
      wcnt_q  <= '0;
      tiles_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      need_q  <= need_d;
      oidx_q  <= oidx_d;
      wcnt_q  <= wcnt_d;
      tiles_q <= tiles_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    need_d    = need_q;
    oidx_d    = oidx_q;
    wcnt_d    = wcnt_q;
    tiles_d   = tiles_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (n_tiles != '0) begin
            tiles_d = n_tiles;
            need_d  = 3'(T);
            state_d = S_FILL;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          need_d = need_q - 3'd1;
          if (need_q == 3'd1) begin
            wcnt_d  = WCW'(WC_LAT);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Counting down to zero gives WC_LAT+1 edges from the last shift.
        if (wcnt_q == '0) begin
          res_d   = wc_Z;
          oidx_d  = '0;
          state_d = S_DRAIN;
        end else begin
          wcnt_d = wcnt_q - WCW'(1);
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (oidx_q == 2'(M - 1)) begin
            oidx_d  = '0;
            tiles_d = tiles_q - NW'(1);
            if (tiles_q == NW'(1)) begin
              state_d = S_FIN;
            end else begin
              need_d  = 3'(M);
              state_d = S_FILL;
            end
          end else begin
            oidx_d = oidx_q + 2'd1;
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign out_data = res_q[oidx_q*DW +: DW];
  assign out_last = (state_q == S_DRAIN) && (oidx_q == 2'(M - 1)) &&
                    (tiles_q == NW'(1));
endmodule

// File: tb/tb_wc_tile_sched.sv
// Self-checking bench for wc_tile_sched with a behavioural WC core model.
module tb_wc_tile_sched;
  import wc_pkg::*;

  localparam int NW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [NW-1:0]   n_tiles = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic [T*DW-1:0] wc_D;
  logic [M*DW-1:0] wc_Z;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wc_tile_sched #(
    .DW     (DW),
    .M      (M),
    .R      (R),
    .T      (T),
    .WC_LAT (WC_LAT),
    .NW     (NW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_tiles   (n_tiles),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .wc_D      (wc_D),
    .wc_Z      (wc_Z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // WC core model: Z[j] = D[j] + D[j+1], WC_LAT register stages.
  logic [M*DW-1:0] zf;
  logic [M*DW-1:0] z1 = '0;
  logic [M*DW-1:0] z2 = '0;
  always_comb begin
    zf = '0;
    for (int j = 0; j < M; j++) zf[j*DW +: DW] = wc_D[j*DW +: DW] + wc_D[(j+1)*DW +: DW];
  end
  always @(posedge clk) begin
    z1 <= zf;
    z2 <= z1;
  end
  assign wc_Z = z2;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_in_ready",  80'(in_ready),  80'(0));
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_out_data",  80'(out_data),  80'(0));
    chk("rst_out_last",  80'(out_last),  80'(0));
    chk("rst_busy",      80'(busy),      80'(0));
    chk("rst_done",      80'(done),      80'(0));
    chk("rst_wc_D",      80'(wc_D),      80'(0));
  endtask

  // Runs one row from the current negedge; expectations come from the list
  // of accepted input samples (tile t uses samples 3t..3t+6).
  task automatic run_row(input int n, input bit rnd, input bit bp, input bit abort, input bit repulse);
    wc_sample_t      acc[$];
    int              outs = 0, dones = 0, cyc = 0, first_out = -1, done_cyc = -1;
    int              g, t, j, base;
    bit              saw_inready = 0, pulsed = 0, fin = 0, aborted = 0, stalled = 0;
    logic [DW-1:0]   held = '0;
    logic [DW-1:0]   eo;
    logic [T*DW-1:0] ew;

    start     = 1'b1;
    n_tiles   = NW'(n);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    start   = 1'b0;
    n_tiles = NW'($urandom);

    while (!fin && cyc < 80 + 40 * n) begin
      if (abort && outs == 1) begin
        chk("pre_abort_valid", 80'(out_valid), 80'(1));
        rst = 1'b0;
        #1;
        chk_reset();
        chk("abort_no_done", 80'(dones), 80'(0));
        @(negedge clk);
        rst = 1'b1;
        aborted = 1;
        break;
      end
      in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data   = rnd ? DW'($urandom) : DW'(acc.size() + 1);
      out_ready = bp ? ((cyc % 2) == 0) : 1'b1;
      if (repulse && !pulsed && in_ready && acc.size() == 2) begin
        start   = 1'b1;
        n_tiles = NW'(n + 3);
        pulsed  = 1;
      end else begin
        start = 1'b0;
      end
      #1;
      if (in_ready) saw_inready = 1;
      chk("busy", 80'(busy), 80'(1));
      if (acc.size() >= T) begin
        base = acc.size() - T;
        for (int k = 0; k < T; k++) ew[k*DW +: DW] = acc[base + k];
        chk("wc_D", 80'(wc_D), 80'(ew));
      end
      if (out_valid) begin
        if (first_out < 0) first_out = cyc;
        if (stalled) chk("stall_hold", 80'(out_data), 80'(held));
        g = outs;
        t = g / M;
        j = g % M;
        if (t * M + j + 1 < acc.size()) begin
          eo = acc[t*M + j] + acc[t*M + j + 1];
          chk("out_data", 80'(out_data), 80'(eo));
        end else begin
          chk("out_before_window", 80'(acc.size()), 80'(t * M + j + 2));
        end
        chk("out_last", 80'(out_last), 80'(g == M * n - 1));
        if (out_ready) outs++;
        stalled = !out_ready;
        held    = out_data;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        chk("done_quiet", 80'({in_ready, out_valid}), 80'(0));
        fin = 1;
      end
      if (in_valid && in_ready) acc.push_back(in_data);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (aborted) return;

    chk("row_finished", 80'(fin), 80'(1));
    chk("done_count", 80'(dones), 80'(1));
    chk("out_count", 80'(outs), 80'(M * n));
    chk("in_handshakes", 80'(acc.size()), 80'((n > 0) ? M * n + R - 1 : 0));
    if (!rnd && !bp) begin
      if (n > 0) chk("first_out_cyc", 80'(first_out), 80'(T + WC_LAT + 1));
      chk("done_cyc", 80'(done_cyc),
          80'((n > 0) ? (T + WC_LAT + 1 + M) + (n - 1) * (2 * M + WC_LAT + 1) : 0));
    end
    if (n == 0) chk("zero_no_inready", 80'(saw_inready), 80'(0));
    #1;
    chk("done_pulse", 80'(done), 80'(0));
    chk("busy_after", 80'(busy), 80'(0));
  endtask

  initial begin
    #2;
    chk_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_row(1, 0, 0, 0, 0);   // single tile, inputs 1..7
    run_row(3, 0, 0, 0, 0);   // overlapping windows, inputs 1..13
    run_row(0, 0, 0, 0, 0);   // zero tiles
    run_row(4, 1, 1, 0, 0);   // random input valid, toggling out_ready
    run_row(2, 0, 0, 1, 0);   // reset after first output
    run_row(1, 0, 0, 0, 0);   // clean tile after the abort
    run_row(2, 0, 0, 0, 1);   // start re-pulsed during FILL
    for (int i = 0; i < 3; i++) run_row($urandom_range(1, 5), 1, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
